vga_dma_stream: RTL and testbench
=================================

Name: vga_dma_stream

Overview:
- Parametrised successor to the 1-bit VGA DMA controller.
- CPU programs base address, byte length and mode over an Avalon-MM slave. An Avalon-MM read master fetches DATA_W-bit words into an internal FIFO, which drains to an Avalon-ST source feeding the pixel serialiser.
- Adds configurable width and depth, FIFO-gated fetching, loop (continuous frame) mode, abort, and an irq enable.

Parameters:
- DATA_W, 16, master/stream word width; 8, 16 or 32.
- ADDR_W, 32, master address width.
- LEN_W, 24, LENGTH register width in bytes; ≤ 32.
- FIFO_DEPTH, 64, FIFO entries; power of 2, ≥ 4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_s1_chipselect  in  1  slave select
- avs_s1_address  in  3  word register index
- avs_s1_read  in  1  register read strobe
- avs_s1_write  in  1  register write strobe
- avs_s1_writedata  in  32  write data
- avs_s1_readdata  out  32  read data, registered
- avs_s1_waitrequest  out  1  tied 0
- avs_s1_irq  out  1  frame-done interrupt
- avm_read_address  out  ADDR_W  byte address
- avm_read_read  out  1  read request
- avm_read_readdata  in  DATA_W  returned word; valid when read && !waitrequest
- avm_read_waitrequest  in  1  slave stall
- aso_data  out  DATA_W  pixel word
- aso_valid  out  1  FIFO not empty
- aso_ready  in  1  sink accepts

Behaviour:
- Registers (cs && write): 0 S_ADDR[ADDR_W-1:0]; 1 LENGTH[LEN_W-1:0]; 2 CONTROL (b0 fixed_addr, b1 loop, b2 irq_en); 3 CMD (b0 start, b1 abort, self-clearing, read 0); 4 STATUS (b0 done, b1 busy; write 1 to b0 clears done and irq); 5 FIFO_LEVEL (read-only); 6-7 read 0.
- Register reads: readdata updated on the clock edge after cs && read (1-cycle latency); unused bits 0.
- Reset values: all registers 0, readdata 0, irq 0, avm_read_read 0, avm_read_address 0, aso_valid 0, FIFO empty, state IDLE.
- BYTES = DATA_W/8. Word count N = LENGTH >> log2(BYTES); low bits ignored.
- At start and at every loop wrap, S_ADDR and N are latched into working copies. CPU writes while busy affect only the next latch.
- State machine:
  - IDLE: busy=0. Start → LOAD. Start while not IDLE is ignored.
  - LOAD: latch addr/count, cnt=0. N==0 → DONE (no reads issued). Otherwise → REQ.
  - REQ: when FIFO free slots ≥ 1, drive address = base + cnt*BYTES (or base if fixed_addr), assert read → WAIT. Otherwise hold in REQ with read=0.
  - WAIT: read and address held stable while waitrequest=1. On waitrequest=0: push readdata, deassert read, cnt+1. If cnt+1 == N → DONE, else → REQ.
  - DONE: set STATUS.done; irq=1 if irq_en. If loop and no abort pending → LOAD (frame repeats, no idle gap beyond 1 cycle). Else → IDLE.
- Single outstanding read; address arithmetic wraps modulo 2^ADDR_W.
- FIFO:
  - Show-ahead: aso_data = head entry, aso_valid = !empty, pop on aso_valid && aso_ready.
  - Simultaneous push and pop keep the level unchanged.
  - Push never occurs when full (guaranteed by REQ gating).
- Abort:
  - Sets abort_pending. In REQ or LOAD → IDLE next cycle.
  - In WAIT, read is held until waitrequest=0, returned data is discarded, then → IDLE.
  - FIFO flushed on leaving to IDLE via abort.
  - done not set; irq unchanged. Abort in IDLE has no effect.
- Start and abort in the same write: abort wins, start ignored.
- STATUS.done clear and a new DONE in the same cycle: set wins.
- reset_n low mid-transfer: immediate return to reset values; a bus read in flight is dropped.

Decomposition:
- Package vga_dma_pkg: register offsets (S_ADDR, LENGTH, CONTROL, CMD, STATUS, FIFO_LEVEL), CONTROL/CMD/STATUS bit indices, state encoding (IDLE, LOAD, REQ, WAIT, DONE).
- Sub-module vga_dma_fifo: synchronous show-ahead FIFO, parameters DATA_W and FIFO_DEPTH, outputs full, empty and level[log2(FIFO_DEPTH):0].

Test Plan:
- S_ADDR=0x1000, LENGTH=8, DATA_W=16, start, sink always ready, waitrequest 0-2 random cycles → exactly 4 reads at 0x1000/02/04/06, stream data in order, done=1, busy=0, irq=1 (irq_en=1). Write STATUS=1 → irq=0, done=0.
- LENGTH=0, start → zero reads; done=1 within 3 cycles.
- FIFO_DEPTH=4, LENGTH=32, aso_ready=0 → exactly 4 reads then REQ stalls, FIFO_LEVEL=4, read=0. Release ready → remaining 12 reads complete, 16 words total, order preserved.
- fixed_addr=1, S_ADDR=0x2000, LENGTH=6 → 3 reads, all at 0x2000.
- loop=1, LENGTH=4 → addresses 0x1000, 0x1002, 0x1000, 0x1002…; done and irq set after each frame. Abort during WAIT with waitrequest=1 → read held until waitrequest=0, that word not pushed, FIFO_LEVEL=0, busy=0 next cycle.
- Reset_n asserted mid-WAIT → read=0, aso_valid=0, all registers 0. Start while busy → no restart (address sequence unchanged).

Source files
------------

// File: rtl/vga_dma_pkg.sv
// vga_dma_pkg: shared definitions for the VGA DMA stream controller.
// Holds the CSR offsets, the CONTROL/CMD/STATUS bit positions, the packed
// CONTROL payload and the sequencer state encoding.
package vga_dma_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    // CSR word offsets
    localparam logic [REG_ADDR_W-1:0] REG_S_ADDR     = 3'd0;
    localparam logic [REG_ADDR_W-1:0] REG_LENGTH     = 3'd1;
    localparam logic [REG_ADDR_W-1:0] REG_CONTROL    = 3'd2;
    localparam logic [REG_ADDR_W-1:0] REG_CMD        = 3'd3;
    localparam logic [REG_ADDR_W-1:0] REG_STATUS     = 3'd4;
    localparam logic [REG_ADDR_W-1:0] REG_FIFO_LEVEL = 3'd5;

    // Bit positions
    localparam int unsigned CTRL_FIXED_ADDR = 0;
    localparam int unsigned CTRL_LOOP       = 1;
    localparam int unsigned CTRL_IRQ_EN     = 2;
    localparam int unsigned CTRL_W          = 3;
    localparam int unsigned CMD_START       = 0;
    localparam int unsigned CMD_ABORT       = 1;
    localparam int unsigned STAT_DONE       = 0;
    localparam int unsigned STAT_BUSY       = 1;

    // CONTROL register payload, laid out to match its bit positions
    typedef struct packed {
        logic irq_en;
        logic loop;
        logic fixed_addr;
    } ctrl_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/vga_dma_fifo.sv
// vga_dma_fifo: synchronous show-ahead FIFO between the read master and the
// stream source.
//   i_push/i_data : write one entry (caller guarantees not full)
//   i_pop         : consume head entry when not empty
//   i_flush       : discard all entries (overrides push/pop)
//   o_data        : head entry, valid whenever !o_empty
//   o_full/o_empty/o_level : occupancy
module vga_dma_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers and level; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/vga_dma_stream.sv
// vga_dma_stream: CSR-programmed DMA that fetches a frame over an Avalon-MM
// read master into a FIFO and streams it out over Avalon-ST.
//   avs_s1_*        : CPU register slave (1-cycle registered read data), irq
//   avm_read_*      : single-outstanding read master, byte addresses
//   aso_*           : show-ahead pixel word stream
module vga_dma_stream
    import vga_dma_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 24,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  avs_s1_chipselect,
    input  logic [REG_ADDR_W-1:0] avs_s1_address,
    input  logic                  avs_s1_read,
    input  logic                  avs_s1_write,
    input  logic [31:0]           avs_s1_writedata,
    output logic [31:0]           avs_s1_readdata,
    output logic                  avs_s1_waitrequest,
    output logic                  avs_s1_irq,
    output logic [ADDR_W-1:0]     avm_read_address,
    output logic                  avm_read_read,
    input  logic [DATA_W-1:0]     avm_read_readdata,
    input  logic                  avm_read_waitrequest,
    output logic [DATA_W-1:0]     aso_data,
    output logic                  aso_valid,
    input  logic                  aso_ready
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SHIFT = $clog2(BYTES);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_e        r_state;
    dma_state_e        w_next_state;

    logic [ADDR_W-1:0] r_s_addr;
    logic [LEN_W-1:0]  r_length;
    ctrl_t             r_ctrl;
    logic              r_done;
    logic              r_irq;
    logic [31:0]       r_readdata;
    logic              r_abort_pending;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_words;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;

    logic              w_wr;
    logic              w_rd;
    logic              w_cmd_wr;
    logic              w_abort_cmd;
    logic              w_start;
    logic              w_abort;
    logic              w_status_clr;
    logic              w_busy;
    logic [LEN_W-1:0]  w_n;
    logic [LEN_W-1:0]  w_cnt_inc;

    logic              w_latch;
    logic              w_issue;
    logic              w_accept;
    logic              w_push;
    logic              w_flush;
    logic              w_set_done;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [LVL_W-1:0]  w_fifo_level;
    logic [DATA_W-1:0] w_fifo_data;

    assign w_wr         = avs_s1_chipselect && avs_s1_write;
    assign w_rd         = avs_s1_chipselect && avs_s1_read;
    assign w_cmd_wr     = w_wr && (avs_s1_address == REG_CMD);
    assign w_abort_cmd  = w_cmd_wr && avs_s1_writedata[CMD_ABORT];
    // Abort in the same write suppresses start
    assign w_start      = w_cmd_wr && avs_s1_writedata[CMD_START] && !avs_s1_writedata[CMD_ABORT];
    assign w_abort      = r_abort_pending || w_abort_cmd;
    assign w_status_clr = w_wr && (avs_s1_address == REG_STATUS) && avs_s1_writedata[STAT_DONE];
    assign w_busy       = (r_state != ST_IDLE);
    assign w_n          = r_length >> SHIFT;
    assign w_cnt_inc    = r_cnt + LEN_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_LOAD;
            ST_LOAD: begin
                if (w_abort)         w_next_state = ST_IDLE;
                else if (w_n == '0)  w_next_state = ST_DONE;
                else                 w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (w_abort)           w_next_state = ST_IDLE;
                else if (!w_fifo_full) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!avm_read_waitrequest) begin
                    if (w_abort)                 w_next_state = ST_IDLE;
                    else if (w_cnt_inc == r_words) w_next_state = ST_DONE;
                    else                         w_next_state = ST_REQ;
                end
            end
            ST_DONE: begin
                if (r_ctrl.loop && !w_abort) w_next_state = ST_LOAD;
                else                         w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        w_latch    = 1'b0;
        w_issue    = 1'b0;
        w_accept   = 1'b0;
        w_push     = 1'b0;
        w_flush    = 1'b0;
        w_set_done = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_latch = 1'b1;
                w_flush = w_abort;
            end
            ST_REQ: begin
                w_issue = !w_abort && !w_fifo_full;
                w_flush = w_abort;
            end
            ST_WAIT: begin
                // Aborted reads still complete on the bus; their data is dropped
                w_accept = !avm_read_waitrequest;
                w_push   = !avm_read_waitrequest && !w_abort;
                w_flush  = !avm_read_waitrequest && w_abort;
            end
            ST_DONE: begin
                w_set_done = 1'b1;
                w_flush    = w_abort;
            end
            default: ;
        endcase
    end

    // Working copies, read master and abort tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base          <= '0;
            r_words         <= '0;
            r_cnt           <= '0;
            r_read          <= 1'b0;
            r_addr          <= '0;
            r_abort_pending <= 1'b0;
        end else begin
            if (w_latch) begin
                r_base  <= r_s_addr;
                r_words <= w_n;
                r_cnt   <= '0;
            end
            if (w_issue) begin
                r_read <= 1'b1;
                r_addr <= r_ctrl.fixed_addr ? r_base
                                            : r_base + (ADDR_W'(r_cnt) << SHIFT);
            end
            if (w_accept) begin
                r_read <= 1'b0;
                r_cnt  <= w_cnt_inc;
            end
            if (w_next_state == ST_IDLE)  r_abort_pending <= 1'b0;
            else if (w_abort_cmd && w_busy) r_abort_pending <= 1'b1;
        end
    end

    // CPU registers, done/irq and registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_addr   <= '0;
            r_length   <= '0;
            r_ctrl     <= '0;
            r_done     <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_wr) begin
                case (avs_s1_address)
                    REG_S_ADDR:  r_s_addr <= avs_s1_writedata[ADDR_W-1:0];
                    REG_LENGTH:  r_length <= avs_s1_writedata[LEN_W-1:0];
                    REG_CONTROL: r_ctrl   <= ctrl_t'(avs_s1_writedata[CTRL_W-1:0]);
                    default: ;
                endcase
            end
            if (w_status_clr) begin
                r_done <= 1'b0;
                r_irq  <= 1'b0;
            end
            // Later assignment lets a new completion beat a same-cycle clear
            if (w_set_done) begin
                r_done <= 1'b1;
                if (r_ctrl.irq_en) r_irq <= 1'b1;
            end
            if (w_rd) begin
                case (avs_s1_address)
                    REG_S_ADDR:     r_readdata <= 32'(r_s_addr);
                    REG_LENGTH:     r_readdata <= 32'(r_length);
                    REG_CONTROL:    r_readdata <= 32'(r_ctrl);
                    REG_STATUS:     r_readdata <= {30'd0, w_busy, r_done};
                    REG_FIFO_LEVEL: r_readdata <= 32'(w_fifo_level);
                    default:        r_readdata <= '0;
                endcase
            end
        end
    end

    vga_dma_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (avm_read_readdata),
        .i_pop   (aso_ready),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign avs_s1_readdata    = r_readdata;
    assign avs_s1_waitrequest = 1'b0;
    assign avs_s1_irq         = r_irq;
    assign avm_read_address   = r_addr;
    assign avm_read_read      = r_read;
    assign aso_data           = w_fifo_data;
    assign aso_valid          = !w_fifo_empty;

endmodule

// File: tb/tb_vga_dma_stream.sv
// tb_vga_dma_stream: directed bench for vga_dma_stream with a memory slave
// model and address/data scoreboards. FIFO_DEPTH is 4 so stalls are visible.
module tb_vga_dma_stream;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 24;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [2:0] A_SADDR = 3'd0;
    localparam logic [2:0] A_LEN   = 3'd1;
    localparam logic [2:0] A_CTRL  = 3'd2;
    localparam logic [2:0] A_CMD   = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;
    localparam logic [2:0] A_LVL   = 3'd5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              avs_s1_chipselect;
    logic [2:0]        avs_s1_address;
    logic              avs_s1_read;
    logic              avs_s1_write;
    logic [31:0]       avs_s1_writedata;
    logic [31:0]       avs_s1_readdata;
    logic              avs_s1_waitrequest;
    logic              avs_s1_irq;
    logic [ADDR_W-1:0] avm_read_address;
    logic              avm_read_read;
    logic [DATA_W-1:0] avm_read_readdata = '0;
    logic              avm_read_waitrequest = 1'b0;
    logic [DATA_W-1:0] aso_data;
    logic              aso_valid;
    logic              aso_ready;

    vga_dma_stream #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .avs_s1_chipselect    (avs_s1_chipselect),
        .avs_s1_address       (avs_s1_address),
        .avs_s1_read          (avs_s1_read),
        .avs_s1_write         (avs_s1_write),
        .avs_s1_writedata     (avs_s1_writedata),
        .avs_s1_readdata      (avs_s1_readdata),
        .avs_s1_waitrequest   (avs_s1_waitrequest),
        .avs_s1_irq           (avs_s1_irq),
        .avm_read_address     (avm_read_address),
        .avm_read_read        (avm_read_read),
        .avm_read_readdata    (avm_read_readdata),
        .avm_read_waitrequest (avm_read_waitrequest),
        .aso_data             (aso_data),
        .aso_valid            (aso_valid),
        .aso_ready            (aso_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    bit hold_wait = 1'b0;
    bit in_txn    = 1'b0;
    int wait_left = 0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a[15:0] ^ 16'hC35A);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory slave: 0-2 random stall cycles per read, or stall while hold_wait
    always @(posedge clk) begin
        #2;
        if (!reset_n || !avm_read_read) begin
            in_txn = 1'b0;
            avm_read_waitrequest = 1'b0;
        end else begin
            if (!in_txn) begin
                in_txn = 1'b1;
                wait_left = $urandom_range(0, 2);
                avm_read_readdata = mem_word(avm_read_address);
            end else if (wait_left > 0) begin
                wait_left--;
            end
            avm_read_waitrequest = (wait_left > 0) || hold_wait;
        end
    end

    // Scoreboard: handshakes that will complete at the next rising edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_read_read && !avm_read_waitrequest) begin
                if (exp_addr_q.size() == 0) check("extra_read_q", 32'(exp_addr_q.size()), 32'd1);
                else check("read_addr", 32'(avm_read_address), exp_addr_q.pop_front());
            end
            if (aso_valid && aso_ready) begin
                if (exp_data_q.size() == 0) check("extra_word_q", 32'(exp_data_q.size()), 32'd1);
                else check("stream_data", 32'(aso_data), exp_data_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        avs_s1_chipselect = 1'b1; avs_s1_write = 1'b1;
        avs_s1_address = a; avs_s1_writedata = d;
        tick(1);
        avs_s1_chipselect = 1'b0; avs_s1_write = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        avs_s1_chipselect = 1'b1; avs_s1_read = 1'b1; avs_s1_address = a;
        tick(1);
        d = avs_s1_readdata;
        avs_s1_chipselect = 1'b0; avs_s1_read = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] base, input int words, input bit fixed);
        logic [31:0] a;
        for (int i = 0; i < words; i++) begin
            a = fixed ? base : base + 32'(2 * i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(32'(mem_word(a)));
        end
    endtask

    task automatic wait_done(input string tag, input int max_polls);
        logic [31:0] st;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_polls; i++) begin
            csr_read(A_STAT, st);
            if (st[0] && !st[1]) begin ok = 1'b1; break; end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_read_high(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (avm_read_read) begin ok = 1'b1; break; end
            tick(1);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_drained(input string tag);
        tick(4);
        check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
        check({tag, "_data_left"}, 32'(exp_data_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit ok;
        reset_n = 1'b0;
        avs_s1_chipselect = 1'b0; avs_s1_address = '0; avs_s1_read = 1'b0;
        avs_s1_write = 1'b0; avs_s1_writedata = '0; aso_ready = 1'b0;
        tick(3);
        check("rst_read", 32'(avm_read_read), 32'd0);
        check("rst_addr", 32'(avm_read_address), 32'd0);
        check("rst_valid", 32'(aso_valid), 32'd0);
        check("rst_irq", 32'(avs_s1_irq), 32'd0);
        check("rst_readdata", avs_s1_readdata, 32'd0);
        reset_n = 1'b1;
        tick(1);
        for (int r = 0; r < 8; r++) begin
            csr_read(3'(r), rd);
            check($sformatf("rst_reg%0d", r), rd, 32'd0);
        end

        // Basic 4-word frame with irq
        aso_ready = 1'b1;
        csr_write(A_SADDR, 32'h1000);
        csr_write(A_LEN, 32'd8);
        csr_write(A_CTRL, 32'h4);
        csr_read(A_SADDR, rd); check("t1_saddr_rb", rd, 32'h1000);
        csr_read(A_CTRL, rd);  check("t1_ctrl_rb", rd, 32'h4);
        push_frame(32'h1000, 4, 1'b0);
        csr_write(A_CMD, 32'h1);
        wait_done("t1_done", 40);
        check_drained("t1");
        csr_read(A_STAT, rd); check("t1_status", rd, 32'h1);
        check("t1_irq", 32'(avs_s1_irq), 32'd1);
        csr_read(A_CMD, rd); check("t1_cmd_reads0", rd, 32'd0);
        csr_write(A_STAT, 32'h1);
        check("t1_irq_clr", 32'(avs_s1_irq), 32'd0);
        csr_read(A_STAT, rd); check("t1_status_clr", rd, 32'h0);

        // Zero length: no reads, done within 3 cycles
        csr_write(A_LEN, 32'd0);
        csr_write(A_CMD, 32'h1);
        wait_done("t2_done_fast", 3);
        check("t2_irq", 32'(avs_s1_irq), 32'd1);
        check_drained("t2");
        csr_write(A_STAT, 32'h1);

        // FIFO back-pressure: stall after 4 reads, then complete 16
        csr_write(A_CTRL, 32'h0);
        csr_write(A_LEN, 32'd32);
        aso_ready = 1'b0;
        push_frame(32'h1000, 16, 1'b0);
        csr_write(A_CMD, 32'h1);
        tick(30);
        check("t3_reads_before_stall", 32'(exp_addr_q.size()), 32'd12);
        check("t3_read_low", 32'(avm_read_read), 32'd0);
        csr_read(A_LVL, rd);  check("t3_level_full", rd, 32'd4);
        csr_read(A_STAT, rd); check("t3_busy", rd, 32'h2);
        aso_ready = 1'b1;
        wait_done("t3_done", 120);
        check_drained("t3");
        check("t3_no_irq", 32'(avs_s1_irq), 32'd0);
        csr_write(A_STAT, 32'h1);

        // Fixed address
        csr_write(A_CTRL, 32'h1);
        csr_write(A_SADDR, 32'h2000);
        csr_write(A_LEN, 32'd6);
        push_frame(32'h2000, 3, 1'b1);
        csr_write(A_CMD, 32'h1);
        wait_done("t4_done", 40);
        check_drained("t4");
        csr_write(A_STAT, 32'h1);

        // Loop mode, then abort a stalled read
        csr_write(A_CTRL, 32'h6);
        csr_write(A_SADDR, 32'h1000);
        csr_write(A_LEN, 32'd4);
        push_frame(32'h1000, 2, 1'b0);
        push_frame(32'h1000, 2, 1'b0);
        exp_addr_q.push_back(32'h1000);
        csr_write(A_CMD, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_addr_q.size() == 1) begin ok = 1'b1; break; end
            tick(1);
        end
        hold_wait = 1'b1;
        check("t5_two_frames", 32'(ok), 32'd1);
        tick(2);
        check("t5_irq_frame", 32'(avs_s1_irq), 32'd1);
        csr_read(A_STAT, rd); check("t5_done_busy", rd, 32'h3);
        wait_read_high("t5_third_read");
        check("t5_wrap_addr", 32'(avm_read_address), 32'h1000);
        tick(4);
        check("t5_read_stable", 32'(avm_read_read), 32'd1);
        check("t5_addr_stable", 32'(avm_read_address), 32'h1000);
        csr_write(A_STAT, 32'h1);
        csr_write(A_CMD, 32'h2);
        tick(3);
        check("t5_read_held", 32'(avm_read_read), 32'd1);
        hold_wait = 1'b0;
        tick(1);
        csr_read(A_STAT, rd); check("t5_abort_status", rd, 32'h0);
        csr_read(A_LVL, rd);  check("t5_abort_level", rd, 32'd0);
        check("t5_abort_valid", 32'(aso_valid), 32'd0);
        check("t5_abort_irq", 32'(avs_s1_irq), 32'd0);
        check_drained("t5");

        // Start and abort together in idle: nothing starts
        csr_write(A_CTRL, 32'h0);
        csr_write(A_CMD, 32'h3);
        tick(3);
        csr_read(A_STAT, rd); check("t6_start_abort", rd, 32'h0);

        // Start while busy is ignored; new S_ADDR used only on next start
        csr_write(A_SADDR, 32'h3000);
        csr_write(A_LEN, 32'd8);
        push_frame(32'h3000, 4, 1'b0);
        csr_write(A_CMD, 32'h1);
        tick(2);
        csr_write(A_SADDR, 32'h4000);
        csr_write(A_CMD, 32'h1);
        wait_done("t7_done", 60);
        check_drained("t7");
        csr_write(A_STAT, 32'h1);

        // Reset in the middle of a stalled read
        hold_wait = 1'b1;
        csr_write(A_CTRL, 32'h4);
        csr_write(A_CMD, 32'h1);
        wait_read_high("t8_read_issued");
        check("t8_new_base", 32'(avm_read_address), 32'h4000);
        reset_n = 1'b0;
        #1;
        check("t8_rst_read", 32'(avm_read_read), 32'd0);
        check("t8_rst_addr", 32'(avm_read_address), 32'd0);
        check("t8_rst_valid", 32'(aso_valid), 32'd0);
        tick(2);
        reset_n = 1'b1;
        hold_wait = 1'b0;
        tick(1);
        for (int r = 0; r < 6; r++) begin
            csr_read(3'(r), rd);
            check($sformatf("t8_reg%0d", r), rd, 32'd0);
        end
        tick(3);
        check("t8_idle_read", 32'(avm_read_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
